dm_port_arbiter: RTL and testbench

- Shares the single data-memory port between the core (PS/DAG-issued accesses) and a DMA requester.
- Sits between PS/DAG/bus-connect outputs and the memory block's DM control/address/data inputs.
- Core has priority. DMA is guaranteed a slot after a bounded wait, enforced by stalling the core through arb_ps_stall.
- Routes DM read data back to the DMA requester with one-cycle latency.

---
 rtl/dm_port_arbiter.sv | 91 +++++++++
 tb/tb_dm_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the data-memory port between core and DMA.
// The core has priority; a bounded starvation counter guarantees DMA a slot.
module dm_port_arbiter #(
  parameter int DMA_SIZE     = 16,
  parameter int DMD_SIZE     = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dm_cslt,
  input  logic                ps_dm_wrb,
  input  logic [DMA_SIZE-1:0] dg_dm_add,
  input  logic [DMD_SIZE-1:0] bc_dt,
  input  logic                dma_req,
  input  logic                dma_wrb,
  input  logic [DMA_SIZE-1:0] dma_add,
  input  logic [DMD_SIZE-1:0] dma_wdt,
  input  logic [DMD_SIZE-1:0] dm_arb_dt,
  output logic                arb_dm_cslt,
  output logic                arb_dm_wrb,
  output logic [DMA_SIZE-1:0] arb_dm_add,
  output logic [DMD_SIZE-1:0] arb_dm_dt,
  output logic                arb_ps_stall,
  output logic                dma_ack,
  output logic                dma_rvld,
  output logic [DMD_SIZE-1:0] dma_rdt
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] wcnt;
  logic          rtn_dma;
  logic          starved;
  logic          gnt_core;
  logic          gnt_dma;

  // Grant decision: core wins unless a pending DMA has waited long enough.
  always_comb begin
    starved  = dma_req & (wcnt >= LIMIT);
    gnt_core = 1'b0;
    gnt_dma  = 1'b0;
    if (!reset) begin
      gnt_core = ps_dm_cslt & ~starved;
      gnt_dma  = dma_req & ~gnt_core;
    end
  end

  // Memory command mux and handshakes; nothing leaks out during reset.
  always_comb begin
    arb_dm_cslt  = 1'b0;
    arb_dm_wrb   = 1'b0;
    arb_dm_add   = '0;
    arb_dm_dt    = '0;
    unique case (1'b1)
      gnt_core: begin
        arb_dm_cslt = 1'b1;
        arb_dm_wrb  = ps_dm_wrb;
        arb_dm_add  = dg_dm_add;
        arb_dm_dt   = bc_dt;
      end
      gnt_dma: begin
        arb_dm_cslt = 1'b1;
        arb_dm_wrb  = dma_wrb;
        arb_dm_add  = dma_add;
        arb_dm_dt   = dma_wdt;
      end
      default: ;
    endcase
    dma_ack      = gnt_dma;
    arb_ps_stall = ps_dm_cslt & gnt_dma;
    dma_rvld     = rtn_dma & ~reset;
    dma_rdt      = dma_rvld ? dm_arb_dt : '0;
  end

  // Starvation counter and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset || gnt_dma || !dma_req) begin
      wcnt <= '0;
    end else if (wcnt != LIMIT) begin
      wcnt <= wcnt + CW'(1);
    end
    if (reset) begin
      rtn_dma <= 1'b0;
    end else begin
      rtn_dma <= gnt_dma & ~dma_wrb;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: directed checks of dm_port_arbiter.
// Two instances: STARVE_LIMIT=4 (u4) and STARVE_LIMIT=0 (u0).
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_dm_cslt;
  logic        ps_dm_wrb;
  logic [15:0] dg_dm_add;
  logic [15:0] bc_dt;
  logic        dma_req;
  logic        dma_wrb;
  logic [15:0] dma_add;
  logic [15:0] dma_wdt;
  logic [15:0] dm_arb_dt;

  logic        cslt, wrb, stall, ack, rvld;
  logic [15:0] add, dt, rdt;
  logic        z_cslt, z_wrb, z_stall, z_ack, z_rvld;
  logic [15:0] z_add, z_dt, z_rdt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.STARVE_LIMIT(4)) u4 (
    .clk(clk), .reset(reset),
    .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
    .dg_dm_add(dg_dm_add), .bc_dt(bc_dt),
    .dma_req(dma_req), .dma_wrb(dma_wrb),
    .dma_add(dma_add), .dma_wdt(dma_wdt),
    .dm_arb_dt(dm_arb_dt),
    .arb_dm_cslt(cslt), .arb_dm_wrb(wrb),
    .arb_dm_add(add), .arb_dm_dt(dt),
    .arb_ps_stall(stall), .dma_ack(ack),
    .dma_rvld(rvld), .dma_rdt(rdt)
  );

  dm_port_arbiter #(.STARVE_LIMIT(0)) u0 (
    .clk(clk), .reset(reset),
    .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb),
    .dg_dm_add(dg_dm_add), .bc_dt(bc_dt),
    .dma_req(dma_req), .dma_wrb(dma_wrb),
    .dma_add(dma_add), .dma_wdt(dma_wdt),
    .dm_arb_dt(dm_arb_dt),
    .arb_dm_cslt(z_cslt), .arb_dm_wrb(z_wrb),
    .arb_dm_add(z_add), .arb_dm_dt(z_dt),
    .arb_ps_stall(z_stall), .dma_ack(z_ack),
    .dma_rvld(z_rvld), .dma_rdt(z_rdt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    ps_dm_cslt = 1'b1;
    ps_dm_wrb  = 1'b0;
    dg_dm_add  = 16'h0000;
    bc_dt      = 16'h0000;
    dma_req    = 1'b1;
    dma_wrb    = 1'b0;
    dma_add    = 16'h0000;
    dma_wdt    = 16'h0000;
    dm_arb_dt  = 16'hFFFF;
    tick;
    tick;
    settle;
    chk("rst_cslt", 32'(cslt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rvld", 32'(rvld), 32'h0);
    chk("rst_rdt", 32'(rdt), 32'h0);

    tick;
    reset      = 1'b0;
    ps_dm_cslt = 1'b0;
    dma_req    = 1'b0;
    settle;
    chk("idle_cslt", 32'(cslt), 32'h0);
    chk("idle_add", 32'(add), 32'h0);

    // 1: core-only read
    tick;
    ps_dm_cslt = 1'b1;
    ps_dm_wrb  = 1'b0;
    dg_dm_add  = 16'h0010;
    bc_dt      = 16'h5555;
    settle;
    chk("t1_cslt", 32'(cslt), 32'h1);
    chk("t1_add", 32'(add), 32'h0010);
    chk("t1_wrb", 32'(wrb), 32'h0);
    chk("t1_dt", 32'(dt), 32'h5555);
    chk("t1_stall", 32'(stall), 32'h0);
    chk("t1_ack", 32'(ack), 32'h0);
    tick;
    ps_dm_cslt = 1'b0;
    settle;
    chk("t1_rvld", 32'(rvld), 32'h0);
    chk("t1_cslt_off", 32'(cslt), 32'h0);

    // 2: DMA-only write
    tick;
    dma_req = 1'b1;
    dma_wrb = 1'b1;
    dma_add = 16'h0020;
    dma_wdt = 16'hBEEF;
    settle;
    chk("t2_ack", 32'(ack), 32'h1);
    chk("t2_cslt", 32'(cslt), 32'h1);
    chk("t2_wrb", 32'(wrb), 32'h1);
    chk("t2_add", 32'(add), 32'h0020);
    chk("t2_dt", 32'(dt), 32'hBEEF);
    chk("t2_stall", 32'(stall), 32'h0);
    tick;
    dma_req = 1'b0;
    settle;
    chk("t2_rvld", 32'(rvld), 32'h0);

    // 3: contention, DMA every 5th cycle
    tick;
    ps_dm_cslt = 1'b1;
    ps_dm_wrb  = 1'b0;
    dg_dm_add  = 16'h0040;
    dma_req    = 1'b1;
    dma_wrb    = 1'b1;
    dma_add    = 16'h0044;
    for (int i = 0; i < 10; i++) begin
      settle;
      chk($sformatf("t3_ack%0d", i), 32'(ack),
          (i % 5 == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t3_stall%0d", i), 32'(stall),
          (i % 5 == 4) ? 32'h1 : 32'h0);
      chk($sformatf("t3_add%0d", i), 32'(add),
          (i % 5 == 4) ? 32'h0044 : 32'h0040);
      tick;
    end
    ps_dm_cslt = 1'b0;
    dma_req    = 1'b0;

    // 4: single DMA read, then three back-to-back
    tick;
    dma_req = 1'b1;
    dma_wrb = 1'b0;
    dma_add = 16'h0030;
    settle;
    chk("t4_ack", 32'(ack), 32'h1);
    chk("t4_wrb", 32'(wrb), 32'h0);
    chk("t4_add", 32'(add), 32'h0030);
    tick;
    dma_req   = 1'b0;
    dm_arb_dt = 16'h1234;
    settle;
    chk("t4_rvld", 32'(rvld), 32'h1);
    chk("t4_rdt", 32'(rdt), 32'h1234);
    tick;
    dm_arb_dt = 16'h9999;
    settle;
    chk("t4_rvld_off", 32'(rvld), 32'h0);
    chk("t4_rdt_off", 32'(rdt), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick;
      dma_req   = (k < 3);
      dma_add   = 16'h0031 + 16'(k);
      dm_arb_dt = 16'hA000 + 16'(k) - 16'h1;
      settle;
      chk($sformatf("t4b_ack%0d", k), 32'(ack),
          (k < 3) ? 32'h1 : 32'h0);
      chk($sformatf("t4b_rvld%0d", k), 32'(rvld),
          (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
      chk($sformatf("t4b_rdt%0d", k), 32'(rdt),
          (k >= 1 && k <= 3) ? 32'hA000 + 32'(k) - 32'h1
                             : 32'h0);
    end

    // 5: reset kills an in-flight DMA read
    tick;
    dma_req = 1'b1;
    dma_wrb = 1'b0;
    dma_add = 16'h0050;
    settle;
    chk("t5_ack", 32'(ack), 32'h1);
    tick;
    reset      = 1'b1;
    ps_dm_cslt = 1'b1;
    ps_dm_wrb  = 1'b1;
    dg_dm_add  = 16'h0060;
    bc_dt      = 16'h4321;
    dm_arb_dt  = 16'h7777;
    settle;
    chk("t5_cslt", 32'(cslt), 32'h0);
    chk("t5_wrb", 32'(wrb), 32'h0);
    chk("t5_add", 32'(add), 32'h0);
    chk("t5_dt", 32'(dt), 32'h0);
    chk("t5_stall", 32'(stall), 32'h0);
    chk("t5_ack", 32'(ack), 32'h0);
    chk("t5_rvld", 32'(rvld), 32'h0);
    chk("t5_rdt", 32'(rdt), 32'h0);
    tick;
    reset      = 1'b0;
    ps_dm_wrb  = 1'b0;
    dma_wrb    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle;
      if (i == 0) chk("t5_rvld_after", 32'(rvld), 32'h0);
      chk($sformatf("t5_ack%0d", i), 32'(ack),
          (i == 4) ? 32'h1 : 32'h0);
      tick;
    end

    // 6: STARVE_LIMIT = 0, DMA always wins
    ps_dm_cslt = 1'b1;
    dg_dm_add  = 16'h0070;
    dma_req    = 1'b1;
    dma_add    = 16'h0074;
    for (int i = 0; i < 3; i++) begin
      settle;
      chk($sformatf("t6_ack%0d", i), 32'(z_ack), 32'h1);
      chk($sformatf("t6_stall%0d", i), 32'(z_stall), 32'h1);
      chk($sformatf("t6_add%0d", i), 32'(z_add), 32'h0074);
      tick;
    end
    dma_req = 1'b0;
    settle;
    chk("t6_core_cslt", 32'(z_cslt), 32'h1);
    chk("t6_core_ack", 32'(z_ack), 32'h0);
    chk("t6_core_stall", 32'(z_stall), 32'h0);
    chk("t6_core_add", 32'(z_add), 32'h0070);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
